// File: rtl/pdes_mc_pkg.sv
// Shared constants and types for the PHOLD memory-controller port logic.
package pdes_mc_pkg;

    // MC request commands
    localparam logic [2:0] MC_CMD_RD      = 3'd1;
    localparam logic [2:0] MC_CMD_WR      = 3'd2;

    // MC response commands
    localparam logic [2:0] MC_RSP_RDDATA  = 3'd2;
    localparam logic [2:0] MC_RSP_WRCMPLT = 3'd3;

    localparam logic [1:0] MC_SIZE_8B     = 2'd3;
    localparam logic [3:0] MC_SCMD_NONE   = 4'd0;

    typedef enum logic [2:0] {
        StArb,
        StDrain,
        StFlush,
        StWait,
        StDone
    } flush_state_e;

    // True for response codes that retire an outstanding request
    function automatic logic rsp_retires(input logic [2:0] cmd);
        return (cmd == MC_RSP_RDDATA) || (cmd == MC_RSP_WRCMPLT);
    endfunction

endpackage

// File: rtl/pdes_sync_fifo.sv
// Single-clock FIFO with occupancy-derived free count; a push into a full
// FIFO (without a simultaneous pop) is dropped.
module pdes_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(Depth):0]   free_cnt
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DepthCnt);
    assign free_cnt = DepthCnt - count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed since reads are qualified by empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

`ifndef SYNTHESIS
    // Overflow means the producer ignored its stall signal
    always_ff @(posedge clk) begin
        if (!i_reset && push && full && !do_pop) begin
            $display("%m: push while full at %0t, entry dropped", $time);
        end
    end
`endif

endmodule

// File: rtl/mc_port_arbiter.sv
// Round-robin arbiter sharing one MC port between NUM_REQ cores, with a
// buffered response return path and a drain/flush sequencer.
module mc_port_arbiter
    import pdes_mc_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 8,
    parameter int unsigned TAG_W        = 16,
    parameter int unsigned RTNCTL_WIDTH = 32,
    parameter int unsigned RS_DEPTH     = 16,
    parameter int unsigned RS_AFULL     = 4
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*3-1:0]      req_cmd,
    input  logic [NUM_REQ*48-1:0]     req_vadr,
    input  logic [NUM_REQ*64-1:0]     req_data,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [2:0]                rsp_cmd,
    output logic [63:0]               rsp_data,
    output logic [TAG_W-1:0]          rsp_tag,
    input  logic [NUM_REQ-1:0]        rsp_stall,
    output logic                      mc_rq_vld,
    output logic [2:0]                mc_rq_cmd,
    output logic [3:0]                mc_rq_scmd,
    output logic [1:0]                mc_rq_size,
    output logic [47:0]               mc_rq_vadr,
    output logic [63:0]               mc_rq_data,
    output logic [RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
    input  logic                      mc_rq_stall,
    input  logic                      mc_rs_vld,
    input  logic [2:0]                mc_rs_cmd,
    input  logic [3:0]                mc_rs_scmd,
    input  logic [63:0]               mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
    output logic                      mc_rs_stall,
    output logic                      mc_rq_flush,
    input  logic                      mc_rs_flush_cmplt,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic [15:0]               outstanding
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned FreeW = $clog2(RS_DEPTH) + 1;

    typedef struct packed {
        logic [2:0]       cmd;
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic [IdxW-1:0]  idx;
    } rs_entry_t;

    flush_state_e state_q, state_d;
    logic              arb_en;

    logic [IdxW-1:0]   rr_ptr_q;
    logic [IdxW-1:0]   win_idx, cand;
    logic              win_found, grant;
    logic [RTNCTL_WIDTH-1:0] rtnctl_d;

    logic [15:0]       outstanding_q;
    logic              rs_retire;

    rs_entry_t         rs_push, rs_head;
    logic              rs_pop, rs_empty, rs_full;
    logic [FreeW-1:0]  rs_free;

    logic                    mc_rq_vld_q;
    logic [2:0]              mc_rq_cmd_q;
    logic [1:0]              mc_rq_size_q;
    logic [47:0]             mc_rq_vadr_q;
    logic [63:0]             mc_rq_data_q;
    logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl_q;
    logic [NUM_REQ-1:0]      rsp_vld_q;
    logic [2:0]              rsp_cmd_q;
    logic [63:0]             rsp_data_q;
    logic [TAG_W-1:0]        rsp_tag_q;
    logic                    mc_rs_stall_q;
    logic                    flush_done_q;

    logic unused_rs;
    assign unused_rs = ^{mc_rs_scmd, mc_rs_rtnctl};

    // Winner is the first valid requester at or after the round-robin pointer
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = rr_ptr_q + IdxW'(i);
            if (!win_found && req_vld[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Reset gating keeps req_gnt low while the block is held in reset
    assign grant   = arb_en && !mc_rq_stall && (outstanding_q != 16'hFFFF) &&
                     win_found && !i_reset;
    assign req_gnt = grant ? (NUM_REQ'(1) << win_idx) : '0;

    // Return control: requester index in the low bits, tag above it
    always_comb begin
        rtnctl_d                   = '0;
        rtnctl_d[IdxW-1:0]         = win_idx;
        rtnctl_d[IdxW +: TAG_W]    = req_tag[win_idx*TAG_W +: TAG_W];
    end

    // Register the granted request onto the MC port and advance the pointer
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rr_ptr_q       <= '0;
            mc_rq_vld_q    <= 1'b0;
            mc_rq_cmd_q    <= '0;
            mc_rq_size_q   <= '0;
            mc_rq_vadr_q   <= '0;
            mc_rq_data_q   <= '0;
            mc_rq_rtnctl_q <= '0;
        end else begin
            mc_rq_vld_q <= grant;
            if (grant) begin
                rr_ptr_q       <= win_idx + IdxW'(1);
                mc_rq_cmd_q    <= req_cmd[win_idx*3 +: 3];
                mc_rq_size_q   <= MC_SIZE_8B;
                mc_rq_vadr_q   <= req_vadr[win_idx*48 +: 48];
                mc_rq_data_q   <= req_data[win_idx*64 +: 64];
                mc_rq_rtnctl_q <= rtnctl_d;
            end
        end
    end

    assign rs_retire = mc_rs_vld && rsp_retires(mc_rs_cmd);

    // Outstanding count; a retire with nothing outstanding is ignored
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            outstanding_q <= '0;
        end else begin
            unique case ({grant, rs_retire})
                2'b10:   outstanding_q <= outstanding_q + 16'd1;
                2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - 16'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_comb begin
        rs_push.cmd  = mc_rs_cmd;
        rs_push.data = mc_rs_data;
        rs_push.tag  = mc_rs_rtnctl[IdxW +: TAG_W];
        rs_push.idx  = mc_rs_rtnctl[IdxW-1:0];
    end

    pdes_sync_fifo #(
        .Width ($bits(rs_entry_t)),
        .Depth (RS_DEPTH)
    ) u_rs_fifo (
        .clk       (clk),
        .i_reset   (i_reset),
        .push      (mc_rs_vld),
        .push_data (rs_push),
        .pop       (rs_pop),
        .pop_data  (rs_head),
        .empty     (rs_empty),
        .full      (rs_full),
        .free_cnt  (rs_free)
    );

    // A stalled head blocks every entry behind it
    assign rs_pop = !rs_empty && !rsp_stall[rs_head.idx];

    // Register popped responses and the MC-side back-pressure
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rsp_vld_q     <= '0;
            rsp_cmd_q     <= '0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            mc_rs_stall_q <= 1'b0;
        end else begin
            rsp_vld_q     <= rs_pop ? (NUM_REQ'(1) << rs_head.idx) : '0;
            mc_rs_stall_q <= (rs_free <= FreeW'(RS_AFULL));
            if (rs_pop) begin
                rsp_cmd_q  <= rs_head.cmd;
                rsp_data_q <= rs_head.data;
                rsp_tag_q  <= rs_head.tag;
            end
        end
    end

    // Flush sequencer state register
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) state_q <= StArb;
        else         state_q <= state_d;
    end

    // Flush sequencer next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb:   if (flush_req) state_d = StDrain;
            StDrain: if (outstanding_q == '0 && rs_empty) state_d = StFlush;
            StFlush: state_d = StWait;
            StWait:  if (mc_rs_flush_cmplt) state_d = StDone;
            StDone:  if (!flush_req) state_d = StArb;
            default: state_d = StArb;
        endcase
    end

    // Flush sequencer outputs
    always_comb begin
        arb_en      = (state_q == StArb);
        mc_rq_flush = (state_q == StFlush);
    end

    // Completion pulse lands the cycle after the MC acknowledges
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) flush_done_q <= 1'b0;
        else         flush_done_q <= (state_q == StWait) && mc_rs_flush_cmplt;
    end

    assign mc_rq_vld    = mc_rq_vld_q;
    assign mc_rq_cmd    = mc_rq_cmd_q;
    assign mc_rq_scmd   = MC_SCMD_NONE;
    assign mc_rq_size   = mc_rq_size_q;
    assign mc_rq_vadr   = mc_rq_vadr_q;
    assign mc_rq_data   = mc_rq_data_q;
    assign mc_rq_rtnctl = mc_rq_rtnctl_q;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_cmd      = rsp_cmd_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = rsp_tag_q;
    assign mc_rs_stall  = mc_rs_stall_q;
    assign flush_done   = flush_done_q;
    assign outstanding  = outstanding_q;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter: arbitration, response routing,
// back-pressure, flush sequencing and asynchronous reset.
module tb_mc_port_arbiter;
    import pdes_mc_pkg::*;

    localparam int NR = 8;
    localparam int TW = 16;
    localparam int RW = 32;

    logic            clk, i_reset;
    logic [NR-1:0]   req_vld, req_gnt, rsp_vld, rsp_stall;
    logic [NR*3-1:0] req_cmd;
    logic [NR*48-1:0] req_vadr;
    logic [NR*64-1:0] req_data;
    logic [NR*TW-1:0] req_tag;
    logic [2:0]      rsp_cmd, mc_rq_cmd, mc_rs_cmd;
    logic [63:0]     rsp_data, mc_rq_data, mc_rs_data;
    logic [TW-1:0]   rsp_tag;
    logic            mc_rq_vld, mc_rq_stall, mc_rs_vld, mc_rs_stall;
    logic [3:0]      mc_rq_scmd, mc_rs_scmd;
    logic [1:0]      mc_rq_size;
    logic [47:0]     mc_rq_vadr;
    logic [RW-1:0]   mc_rq_rtnctl, mc_rs_rtnctl;
    logic            mc_rq_flush, mc_rs_flush_cmplt, flush_req, flush_done;
    logic [15:0]     outstanding;

    int errors = 0;
    int checks = 0;

    mc_port_arbiter #(
        .NUM_REQ(NR), .TAG_W(TW), .RTNCTL_WIDTH(RW), .RS_DEPTH(16), .RS_AFULL(4)
    ) dut (
        .clk(clk), .i_reset(i_reset),
        .req_vld(req_vld), .req_cmd(req_cmd), .req_vadr(req_vadr), .req_data(req_data),
        .req_tag(req_tag), .req_gnt(req_gnt),
        .rsp_vld(rsp_vld), .rsp_cmd(rsp_cmd), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_stall(rsp_stall),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_size(mc_rq_size), .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data),
        .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
        .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
        .mc_rq_flush(mc_rq_flush), .mc_rs_flush_cmplt(mc_rs_flush_cmplt),
        .flush_req(flush_req), .flush_done(flush_done), .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_vld = '0; req_vadr = '0; req_data = '0; req_tag = '0; rsp_stall = '0;
        for (int i = 0; i < NR; i++) req_cmd[i*3 +: 3] = MC_CMD_RD;
        mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0;
        mc_rs_data = '0; mc_rs_rtnctl = '0; mc_rs_flush_cmplt = 1'b0; flush_req = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        req_vld = 8'hFF;
        i_reset = 1'b1;
        tick();
        tick();
        checks++; if (req_gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", req_gnt); end
        checks++; if (mc_rq_vld !== 1'b0) begin errors++; $display("FAIL reset_rq_vld: got %b want 0", mc_rq_vld); end
        checks++; if (rsp_vld !== 8'h00) begin errors++; $display("FAIL reset_rsp_vld: got %h want 00", rsp_vld); end
        checks++; if (outstanding !== 16'h0) begin errors++; $display("FAIL reset_outstanding: got %h want 0", outstanding); end
        checks++; if ({mc_rq_flush, flush_done, mc_rs_stall} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b want 000", {mc_rq_flush, flush_done, mc_rs_stall}); end
        checks++; if ({mc_rq_size, mc_rq_rtnctl} !== 34'h0) begin errors++; $display("FAIL reset_rq_regs: got %h want 0", {mc_rq_size, mc_rq_rtnctl}); end
        i_reset = 1'b0;
        req_vld = '0;
    endtask

    task automatic test_round_robin;
        logic [NR-1:0] exp_gnt;
        logic [2:0]    idx;
        logic [RW-1:0] exp_rtn;
        do_reset();
        for (int i = 0; i < NR; i++) req_tag[i*TW +: TW] = 16'hA000 + 16'(i);
        req_vld = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            idx     = 3'(k % 8);
            exp_gnt = 8'h01 << idx;
            exp_rtn = {13'd0, 16'hA000 + 16'(idx), idx};
            #1;
            checks++; if (req_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %h want %h", k, req_gnt, exp_gnt); end
            tick();
            checks++; if (mc_rq_vld !== 1'b1) begin errors++; $display("FAIL rr_rq_vld[%0d]: got %b want 1", k, mc_rq_vld); end
            checks++; if (mc_rq_rtnctl !== exp_rtn) begin errors++; $display("FAIL rr_rtnctl[%0d]: got %h want %h", k, mc_rq_rtnctl, exp_rtn); end
            checks++; if (mc_rq_size !== 2'd3) begin errors++; $display("FAIL rr_size[%0d]: got %0d want 3", k, mc_rq_size); end
        end
        req_vld = '0;
        tick();
        checks++; if (mc_rq_vld !== 1'b0) begin errors++; $display("FAIL rr_idle_vld: got %b want 0", mc_rq_vld); end
        checks++; if (outstanding !== 16'd9) begin errors++; $display("FAIL rr_outstanding: got %0d want 9", outstanding); end
    endtask

    task automatic test_response;
        do_reset();
        req_vld = 8'h08;
        req_tag[3*TW +: TW] = 16'hBEEF;
        #1;
        checks++; if (req_gnt !== 8'h08) begin errors++; $display("FAIL rsp_gnt: got %h want 08", req_gnt); end
        tick();
        req_vld = '0;
        checks++; if (mc_rq_rtnctl !== 32'h0005F77B) begin errors++; $display("FAIL rsp_rq_rtnctl: got %h want 0005f77b", mc_rq_rtnctl); end
        checks++; if (outstanding !== 16'd1) begin errors++; $display("FAIL rsp_out1: got %0d want 1", outstanding); end
        mc_rs_vld = 1'b1; mc_rs_cmd = MC_RSP_RDDATA; mc_rs_rtnctl = 32'h0005F77B;
        mc_rs_data = 64'h1234;
        tick();
        mc_rs_vld = 1'b0;
        checks++; if (rsp_vld !== 8'h00) begin errors++; $display("FAIL rsp_early: got %h want 00", rsp_vld); end
        checks++; if (outstanding !== 16'd0) begin errors++; $display("FAIL rsp_out0: got %0d want 0", outstanding); end
        tick();
        checks++; if (rsp_vld !== 8'h08) begin errors++; $display("FAIL rsp_vld: got %h want 08", rsp_vld); end
        checks++; if (rsp_tag !== 16'hBEEF) begin errors++; $display("FAIL rsp_tag: got %h want beef", rsp_tag); end
        checks++; if (rsp_data !== 64'h1234) begin errors++; $display("FAIL rsp_data: got %h want 1234", rsp_data); end
        checks++; if (rsp_cmd !== MC_RSP_RDDATA) begin errors++; $display("FAIL rsp_cmd: got %0d want 2", rsp_cmd); end
        tick();
        checks++; if (rsp_vld !== 8'h00) begin errors++; $display("FAIL rsp_one_shot: got %h want 00", rsp_vld); end
    endtask

    task automatic test_rq_stall;
        do_reset();
        req_vld = 8'h06;
        mc_rq_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_gnt !== 8'h00) begin errors++; $display("FAIL stall_gnt[%0d]: got %h want 00", k, req_gnt); end
            tick();
            checks++; if (mc_rq_vld !== 1'b0) begin errors++; $display("FAIL stall_rq_vld[%0d]: got %b want 0", k, mc_rq_vld); end
        end
        mc_rq_stall = 1'b0;
        #1;
        checks++; if (req_gnt !== 8'h02) begin errors++; $display("FAIL stall_resume_gnt: got %h want 02", req_gnt); end
        tick();
        checks++; if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl[2:0] !== 3'd1) begin errors++; $display("FAIL stall_resume_rq: got vld=%b idx=%0d want vld=1 idx=1", mc_rq_vld, mc_rq_rtnctl[2:0]); end
        checks++; if (req_gnt !== 8'h04) begin errors++; $display("FAIL stall_next_gnt: got %h want 04", req_gnt); end
        req_vld = '0;
        tick();
    endtask

    task automatic test_rs_backpressure;
        logic exp_stall;
        do_reset();
        rsp_stall = 8'h04;
        for (int k = 0; k < 13; k++) begin
            mc_rs_vld = 1'b1; mc_rs_cmd = MC_RSP_RDDATA;
            mc_rs_rtnctl = {13'd0, 16'h0100 + 16'(k), 3'd2};
            mc_rs_data = 64'hD000 + 64'(k);
            tick();
            exp_stall = (k >= 12);
            checks++; if (mc_rs_stall !== exp_stall) begin errors++; $display("FAIL bp_stall[%0d]: got %b want %b", k, mc_rs_stall, exp_stall); end
            checks++; if (rsp_vld !== 8'h00) begin errors++; $display("FAIL bp_held[%0d]: got %h want 00", k, rsp_vld); end
        end
        mc_rs_vld = 1'b0;
        tick();
        checks++; if (mc_rs_stall !== 1'b1) begin errors++; $display("FAIL bp_stall_hold: got %b want 1", mc_rs_stall); end
        rsp_stall = '0;
        for (int j = 0; j < 13; j++) begin
            tick();
            checks++; if (rsp_vld !== 8'h04 || rsp_tag !== 16'h0100 + 16'(j) || rsp_data !== 64'hD000 + 64'(j)) begin
                errors++; $display("FAIL bp_drain[%0d]: got vld=%h tag=%h data=%h want vld=04 tag=%h data=%h", j, rsp_vld, rsp_tag, rsp_data, 16'h0100 + 16'(j), 64'hD000 + 64'(j));
            end
        end
        tick();
        checks++; if (rsp_vld !== 8'h00) begin errors++; $display("FAIL bp_extra: got %h want 00", rsp_vld); end
        tick();
        checks++; if (mc_rs_stall !== 1'b0) begin errors++; $display("FAIL bp_stall_release: got %b want 0", mc_rs_stall); end
    endtask

    task automatic test_flush;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_vld = 8'h01;
            req_tag[TW-1:0] = 16'h0010 + 16'(k);
            flush_req = (k == 2);
            #1;
            checks++; if (req_gnt !== 8'h01) begin errors++; $display("FAIL fl_gnt[%0d]: got %h want 01", k, req_gnt); end
            tick();
            checks++; if (mc_rq_vld !== 1'b1) begin errors++; $display("FAIL fl_rq_vld[%0d]: got %b want 1", k, mc_rq_vld); end
        end
        req_vld = 8'hFF;
        #1;
        checks++; if (req_gnt !== 8'h00) begin errors++; $display("FAIL fl_drain_gnt: got %h want 00", req_gnt); end
        tick();
        checks++; if (outstanding !== 16'd3) begin errors++; $display("FAIL fl_outstanding: got %0d want 3", outstanding); end
        for (int k = 0; k < 3; k++) begin
            mc_rs_vld = 1'b1; mc_rs_cmd = MC_RSP_RDDATA;
            mc_rs_rtnctl = {13'd0, 16'h0010 + 16'(k), 3'd0};
            mc_rs_data = 64'hF0 + 64'(k);
            #1;
            checks++; if (mc_rq_flush !== 1'b0 || req_gnt !== 8'h00) begin errors++; $display("FAIL fl_early[%0d]: got flush=%b gnt=%h want 0/00", k, mc_rq_flush, req_gnt); end
            tick();
        end
        mc_rs_vld = 1'b0;
        checks++; if (outstanding !== 16'd0 || mc_rq_flush !== 1'b0) begin errors++; $display("FAIL fl_c1: got out=%0d flush=%b want 0/0", outstanding, mc_rq_flush); end
        tick();
        checks++; if (mc_rq_flush !== 1'b0) begin errors++; $display("FAIL fl_c2: got %b want 0", mc_rq_flush); end
        checks++; if (rsp_vld !== 8'h01 || rsp_data !== 64'hF2) begin errors++; $display("FAIL fl_last_rsp: got vld=%h data=%h want 01/f2", rsp_vld, rsp_data); end
        tick();
        checks++; if (mc_rq_flush !== 1'b1) begin errors++; $display("FAIL fl_pulse: got %b want 1", mc_rq_flush); end
        tick();
        checks++; if (mc_rq_flush !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL fl_wait: got flush=%b done=%b want 0/0", mc_rq_flush, flush_done); end
        tick();
        mc_rs_flush_cmplt = 1'b1;
        tick();
        mc_rs_flush_cmplt = 1'b0;
        checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL fl_done: got %b want 1", flush_done); end
        tick();
        checks++; if (flush_done !== 1'b0 || req_gnt !== 8'h00) begin errors++; $display("FAIL fl_done_state: got done=%b gnt=%h want 0/00", flush_done, req_gnt); end
        flush_req = 1'b0;
        #1;
        checks++; if (req_gnt !== 8'h00) begin errors++; $display("FAIL fl_done_gnt: got %h want 00", req_gnt); end
        tick();
        checks++; if (req_gnt !== 8'h02) begin errors++; $display("FAIL fl_rearb_gnt: got %h want 02", req_gnt); end
        req_vld = '0;
        tick();
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        req_vld = 8'h01;
        req_tag[TW-1:0] = 16'h0777;
        #1;
        checks++; if (req_gnt !== 8'h01) begin errors++; $display("FAIL rw_gnt: got %h want 01", req_gnt); end
        tick();
        req_vld = '0;
        mc_rs_vld = 1'b1; mc_rs_cmd = MC_RSP_RDDATA;
        mc_rs_rtnctl = {13'd0, 16'h0777, 3'd0}; mc_rs_data = 64'h5555;
        tick();
        mc_rs_vld = 1'b0;
        tick();
        checks++; if (rsp_vld !== 8'h01 || rsp_data !== 64'h5555) begin errors++; $display("FAIL rw_rsp: got vld=%h data=%h want 01/5555", rsp_vld, rsp_data); end
        flush_req = 1'b1;
        tick();
        tick();
        checks++; if (mc_rq_flush !== 1'b1) begin errors++; $display("FAIL rw_flush: got %b want 1", mc_rq_flush); end
        tick();
        rsp_stall = 8'h20;
        for (int k = 0; k < 4; k++) begin
            mc_rs_vld = 1'b1; mc_rs_cmd = MC_RSP_WRCMPLT;
            mc_rs_rtnctl = {13'd0, 16'h00A0 + 16'(k), 3'd5}; mc_rs_data = 64'(k);
            tick();
        end
        mc_rs_vld = 1'b0;
        req_vld = 8'hFF;
        #1;
        checks++; if (req_gnt !== 8'h00) begin errors++; $display("FAIL rw_wait_gnt: got %h want 00", req_gnt); end
        #2;
        i_reset = 1'b1;
        #1;
        checks++; if ({mc_rq_size, mc_rq_rtnctl} !== 34'h0) begin errors++; $display("FAIL rw_async_rq: got %h want 0", {mc_rq_size, mc_rq_rtnctl}); end
        checks++; if ({rsp_data, rsp_tag, rsp_vld} !== '0) begin errors++; $display("FAIL rw_async_rsp: got data=%h tag=%h vld=%h want 0", rsp_data, rsp_tag, rsp_vld); end
        checks++; if ({req_gnt, mc_rq_flush, flush_done, mc_rs_stall} !== '0 || outstanding !== 16'h0) begin errors++; $display("FAIL rw_async_ctl: got gnt=%h out=%0d want 0", req_gnt, outstanding); end
        tick();
        i_reset = 1'b0;
        rsp_stall = '0; flush_req = 1'b0; req_vld = 8'h10;
        #1;
        checks++; if (outstanding !== 16'h0) begin errors++; $display("FAIL rw_post_out: got %0d want 0", outstanding); end
        checks++; if (req_gnt !== 8'h10) begin errors++; $display("FAIL rw_post_arb: got %h want 10", req_gnt); end
        tick();
        req_vld = '0;
        checks++; if (mc_rq_vld !== 1'b1 || outstanding !== 16'd1) begin errors++; $display("FAIL rw_post_rq: got vld=%b out=%0d want 1/1", mc_rq_vld, outstanding); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rsp_vld !== 8'h00) begin errors++; $display("FAIL rw_fifo_discard[%0d]: got %h want 00", k, rsp_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_response();
        test_rq_stall();
        test_rs_backpressure();
        test_flush();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_port_arbiter.md
# mc_port_arbiter

Shares one memory-controller (MC) port between `NUM_REQ` event-processing cores inside the PHOLD engine. Requests are arbitrated round-robin. The requester index is embedded in `mc_rq_rtnctl` so responses can be routed back. Responses pass through an elastic FIFO that throttles the MC with `mc_rs_stall`. A flush sequencer drains the port and runs the MC write-flush handshake before end-of-simulation GVT is reported.

## Interface
- `NUM_REQ`, 8: number of requesting cores (power of 2, 2–16).
- `TAG_W`, 16: requester-private tag width. Must satisfy `TAG_W + $clog2(NUM_REQ) <= RTNCTL_WIDTH`.
- `RTNCTL_WIDTH`, 32: MC rtnctl width.
- `RS_DEPTH`, 16: response FIFO depth (power of 2).
- `RS_AFULL`, 4: free-entry threshold at or below which `mc_rs_stall` is asserted.

Ports:
- `clk`  in  1  personality clock
- `i_reset`  in  1  asynchronous, active-high reset
- `req_vld`  in  NUM_REQ  per-core request valid
- `req_cmd`  in  NUM_REQ*3  MC command
- `req_vadr`  in  NUM_REQ*48  virtual address
- `req_data`  in  NUM_REQ*64  write data
- `req_tag`  in  NUM_REQ*TAG_W  core tag
- `req_gnt`  out  NUM_REQ  one-hot accept, same cycle as request
- `rsp_vld`  out  NUM_REQ  one-hot response valid
- `rsp_cmd`  out  3  response command
- `rsp_data`  out  64  response data
- `rsp_tag`  out  TAG_W  returned tag
- `rsp_stall`  in  NUM_REQ  per-core response back-pressure
- `mc_rq_vld`, `mc_rq_cmd`, `mc_rq_scmd`, `mc_rq_size`, `mc_rq_vadr`, `mc_rq_data`, `mc_rq_rtnctl`  out  1/3/4/2/48/64/RTNCTL_WIDTH  MC request
- `mc_rq_stall`  in  1
- `mc_rs_vld`, `mc_rs_cmd`, `mc_rs_scmd`, `mc_rs_data`, `mc_rs_rtnctl`  in  1/3/4/64/RTNCTL_WIDTH
- `mc_rs_stall`  out  1
- `mc_rq_flush`  out  1
- `mc_rs_flush_cmplt`  in  1
- `flush_req`  in  1  level; start drain and flush
- `flush_done`  out  1  one-cycle pulse
- `outstanding`  out  16  requests issued minus responses received

## Operation
- Round-robin pointer `rr_ptr`. The winner is the first `req_vld` at or after `rr_ptr`. On a grant, `rr_ptr` becomes winner+1, modulo `NUM_REQ`.
- A grant requires all of: state `ARB`, `mc_rq_stall == 0`, and `outstanding < 16'hFFFF`.
- A granted request is registered onto `mc_rq_*`:
  - `mc_rq_size = 2'd3` (8 B)
  - `mc_rq_scmd = 0`
  - `mc_rq_rtnctl = {zero-pad, req_tag, winner_idx}`, with the index in the low bits.
- `mc_rq_vld` is high for exactly one cycle per grant.
- MC responses are pushed into the FIFO unconditionally. Each entry holds cmd, data, tag, and idx.
- The FIFO is popped when it is non-empty and `rsp_stall[head.idx] == 0`. On a pop, `rsp_vld[head.idx]`, `rsp_data`, `rsp_cmd`, and `rsp_tag` are registered. A stalled head blocks the FIFO (head-of-line blocking).
- `mc_rs_stall` is registered from (free entries ≤ `RS_AFULL`). The MC may deliver up to `RS_AFULL` responses after the stall is asserted.
- A push into a full FIFO is a protocol error: the data is dropped and a simulation-only `$display` is issued.
- `outstanding` increments on a grant and decrements on an `mc_rs_vld` whose `rs_cmd` is a read-data or write-complete code. If both happen in the same cycle, it is unchanged.

Flush state machine:
- `ARB`: go to `DRAIN` when `flush_req` is high.
- `DRAIN`: no grants. Go to `FLUSH` when `outstanding == 0` and the FIFO is empty.
- `FLUSH`: `mc_rq_flush = 1` for one cycle, then go to `WAIT`.
- `WAIT`: on `mc_rs_flush_cmplt`, pulse `flush_done` and go to `DONE`.
- `DONE`: go to `ARB` when `flush_req` is low.

## Timing
- Request latency: `req_vld` cycle N gives `req_gnt` in N (combinational) and `mc_rq_vld` in N+1.
- Response latency: `mc_rs_vld` cycle N into an empty FIFO with no stall gives `rsp_vld` in N+2 (write in N, registered pop in N+1).
- `mc_rs_stall` reflects FIFO occupancy with one cycle of lag.
- Reset values:
  - All outputs are 0; `rr_ptr = 0`; state is `ARB`; the FIFO is empty; `outstanding = 0`.
  - Reset mid-operation discards queued responses and in-flight accounting immediately. Any flush handshake in progress is abandoned.
- If `flush_req` rises in the same cycle as a grant, the grant completes, then the state moves to `DRAIN`.

## Structure
- Package `pdes_mc_pkg` holds:
  - MC command constants: `MC_CMD_RD = 3'd1`, `MC_CMD_WR = 3'd2`, `MC_RSP_RDDATA = 3'd2`, `MC_RSP_WRCMPLT = 3'd3`.
  - `MC_SIZE_8B`.
  - The flush state enum.
- Sub-module `pdes_sync_fifo`: width and depth parameters, push/pop/empty/full/free-count outputs, used for the response buffer.

## Test plan
- All 8 cores assert `req_vld` continuously with no stall → grants follow the order 0,1,…,7,0; each `mc_rq_rtnctl[2:0]` equals its core index.
- Core 3 reads with `tag = 16'hBEEF` and the MC returns rtnctl `{16'hBEEF, 3'd3}` with `data = 64'h1234` → `rsp_vld[3]` fires 2 cycles later with `rsp_tag = BEEF` and `rsp_data = 1234`.
- `mc_rq_stall` is held high for 5 cycles with requests pending → no `mc_rq_vld` and no `req_gnt` in that window; grants resume the cycle after the stall drops.
- `rsp_stall[2]` is held while 13 responses for core 2 arrive → `mc_rs_stall` asserts once free entries ≤ 4; no entries are lost; all 13 are delivered in order after release.
- `flush_req` is asserted with 3 reads outstanding → no grants; `mc_rq_flush` pulses only after the 3rd response has drained; `flush_done` pulses the cycle after `mc_rs_flush_cmplt`.
- `i_reset` is asserted asynchronously mid-`WAIT` with the FIFO holding 4 entries → all outputs are 0 immediately; after release, state is `ARB` and `outstanding = 0`.
